seq_shift_add_mult: RTL and testbench

//  Parametrised sequential shift-and-add multiplier; successor to the 4x4 combinational array multiplier.

---
 rtl/seq_shift_add_mult_pkg.sv | 24 ++
 rtl/seq_shift_add_mult_if.sv | 23 ++
 rtl/seq_shift_add_mult_shift_add_step.sv | 28 ++
 rtl/seq_shift_add_mult.sv | 117 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Operand magnitudes are taken here so the datapath is always unsigned.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MAX_WIDTH = 16;

    function automatic logic [MAX_WIDTH:0] abs_ext(
        input logic [MAX_WIDTH:0] value,
        input logic               sign_en
    );
        if (sign_en && value[MAX_WIDTH]) begin
            abs_ext = -value;
        end else begin
            abs_ext = value;
        end
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
// The master drives requests, the slave (multiplier) answers.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_mult_shift_add_step.sv
// One accumulation step: add the shifted multiplicand when the
// current multiplier bit is set.
module shift_add_step
    import mult_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int AW    = 2 * WIDTH + 1,
    localparam int SW    = $clog2(WIDTH + 1)
) (
    input  logic [AW-1:0] acc_i,
    input  logic [WIDTH:0] mcand_i,
    input  logic          mult_bit_i,
    input  logic [SW-1:0] step_i,
    output logic [AW-1:0] acc_o
);

    logic [AW-1:0] addend;

    // Partial product for this step, zero when the bit is clear
    always_comb begin
        addend = '0;
        if (mult_bit_i) begin
            addend = AW'(mcand_i) << step_i;
        end
        acc_o = acc_i + addend;
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Signed operands are multiplied as magnitudes, sign applied at the end.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_shift_add_mult_if.slave    bus
);

    localparam int AW  = 2 * WIDTH + 1;
    localparam int PW  = 2 * WIDTH;
    localparam int SW  = $clog2(WIDTH + 1);
    localparam int PAD = MAX_WIDTH + 1 - WIDTH;

    typedef logic [WIDTH:0] mag_t;

    state_t        state_q;
    mag_t          mcand_q;
    mag_t          mult_q;
    logic [AW-1:0] acc_q;
    logic [SW-1:0] step_q;
    logic          sign_q;
    logic          busy_q;
    logic          done_q;
    logic [PW-1:0] product_q;

    mag_t          mcand_d;
    mag_t          mult_d;
    logic          sign_d;
    logic [AW-1:0] acc_d;
    logic          last_step;
    logic [PW-1:0] prod_mag;
    logic [PW-1:0] result_d;

    shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i      (acc_q),
        .mcand_i    (mcand_q),
        .mult_bit_i (mult_q[0]),
        .step_i     (step_q),
        .acc_o      (acc_d)
    );

    // Operand capture values, end-of-run detection and signed result
    always_comb begin
        mcand_d = mag_t'(abs_ext(
            {{PAD{bus.is_signed & bus.a[WIDTH-1]}}, bus.a},
            bus.is_signed));
        mult_d = mag_t'(abs_ext(
            {{PAD{bus.is_signed & bus.b[WIDTH-1]}}, bus.b},
            bus.is_signed));
        sign_d = bus.is_signed
               & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        last_step = (step_q == SW'(WIDTH - 1))
                 || ((EARLY_EXIT != 0)
                     && ((mult_q >> 1) == '0));
        prod_mag = acc_d[PW-1:0];
        result_d = sign_q ? -prod_mag : prod_mag;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand_q <= mcand_d;
                        mult_q  <= mult_d;
                        sign_q  <= sign_d;
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    mult_q <= mult_q >> 1;
                    step_q <= step_q + SW'(1);
                    if (last_step) begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= result_d;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: W=4 fixed and early-exit copies
// share stimulus; a W=8 copy runs directed and random operations.
module tb_seq_shift_add_mult;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic       st4, sg4;
    logic [3:0] a4, b4;
    logic       st8, sg8;
    logic [7:0] a8, b8;

    seq_shift_add_mult_if #(.WIDTH(4)) if0 ();
    seq_shift_add_mult_if #(.WIDTH(4)) if1 ();
    seq_shift_add_mult_if #(.WIDTH(8)) if2 ();

    assign if0.start     = st4;
    assign if0.is_signed = sg4;
    assign if0.a         = a4;
    assign if0.b         = b4;
    assign if1.start     = st4;
    assign if1.is_signed = sg4;
    assign if1.a         = a4;
    assign if1.b         = b4;
    assign if2.start     = st8;
    assign if2.is_signed = sg8;
    assign if2.a         = a8;
    assign if2.b         = b8;

    seq_shift_add_mult #(.WIDTH(4), .EARLY_EXIT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    seq_shift_add_mult #(.WIDTH(4), .EARLY_EXIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    seq_shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] last4;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Runs one W=4 op on both copies for a fixed 12-cycle window
    task automatic op4(input string tag, input logic s,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] ep,
                       input int el0, input int el1,
                       input int poke);
        int l0, l1, nd0, nd1;
        logic [7:0] p0, p1;
        l0 = 0; l1 = 0; nd0 = 0; nd1 = 0; p0 = '0; p1 = '0;
        st4 = 1'b1; sg4 = s; a4 = a; b4 = b;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == poke) begin
                st4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
            end else begin
                st4 = 1'b0; a4 = 'x; b4 = 'x;
            end
            if (c == 1) begin
                check({tag, "_busy0"}, 32'(if0.busy), 1);
                check({tag, "_busy1"}, 32'(if1.busy), 1);
                check({tag, "_hold0"}, 32'(if0.product), 32'(last4));
            end
            if (if0.done) begin
                nd0++;
                if (l0 == 0) begin l0 = c; p0 = if0.product; end
            end
            if (if1.done) begin
                nd1++;
                if (l1 == 0) begin l1 = c; p1 = if1.product; end
            end
        end
        check({tag, "_lat0"}, 32'(l0), 32'(el0));
        check({tag, "_lat1"}, 32'(l1), 32'(el1));
        check({tag, "_p0"}, 32'(p0), 32'(ep));
        check({tag, "_p1"}, 32'(p1), 32'(ep));
        check({tag, "_ndone0"}, 32'(nd0), 1);
        check({tag, "_ndone1"}, 32'(nd1), 1);
        check({tag, "_kept0"}, 32'(if0.product), 32'(ep));
        last4 = ep;
    endtask

    // Runs one W=8 op and checks it against an arithmetic model
    task automatic op8(input string tag, input logic s,
                       input logic [7:0] a, input logic [7:0] b);
        logic [15:0] e;
        logic [8:0]  mb;
        int el, l;
        if (s) begin
            e = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
            mb = b[7] ? 9'(-$signed({b[7], b})) : {1'b0, b};
        end else begin
            e = {8'b0, a} * {8'b0, b};
            mb = {1'b0, b};
        end
        el = 2;
        for (int i = 0; i < 9; i++) begin
            if (mb[i]) el = i + 2;
        end
        l = 0;
        st8 = 1'b1; sg8 = s; a8 = a; b8 = b;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            st8 = 1'b0; a8 = 'x; b8 = 'x;
            if (if2.done) begin l = c; break; end
        end
        check({tag, "_done"}, 32'(if2.done), 1);
        check({tag, "_lat"}, 32'(l), 32'(el));
        check({tag, "_p"}, 32'(if2.product), 32'(e));
    endtask

    initial begin
        int l, nd;
        rst_n = 1'b0;
        st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
        st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
        last4 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy0", 32'(if0.busy), 0);
        check("rst_done0", 32'(if0.done), 0);
        check("rst_prod0", 32'(if0.product), 0);
        check("rst_busy1", 32'(if1.busy), 0);
        check("rst_prod2", 32'(if2.product), 0);
        rst_n = 1'b1;
        @(negedge clk);

        op4("u15x15", 0, 4'd15, 4'd15, 8'hE1, 5, 5, 0);
        op4("sm8xm8", 1, 4'b1000, 4'b1000, 8'h40, 5, 5, 0);
        op4("sm3x5", 1, 4'b1101, 4'd5, 8'hF1, 5, 4, 0);
        op4("u7x1", 0, 4'd7, 4'd1, 8'h07, 5, 2, 0);
        op4("u9x0", 0, 4'd9, 4'd0, 8'h00, 5, 2, 0);
        op4("u3x4", 0, 4'd3, 4'd4, 8'h0C, 5, 4, 0);
        op4("s7xm1", 1, 4'd7, 4'b1111, 8'hF9, 5, 2, 0);
        op4("sm8x7", 1, 4'b1000, 4'd7, 8'hC8, 5, 4, 0);
        op4("u15x8", 0, 4'd15, 4'd8, 8'h78, 5, 5, 0);
        op4("s0xm8", 1, 4'd0, 4'b1000, 8'h00, 5, 5, 0);
        op4("ignore", 0, 4'd2, 4'd15, 8'h1E, 5, 5, 2);

        st4 = 1'b1; sg4 = 1'b0; a4 = 4'd2; b4 = 4'd9;
        l = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (if0.done) begin l = c; break; end
        end
        check("b2b_lat1", 32'(l), 5);
        check("b2b_p1", 32'(if0.product), 32'h12);
        check("b2b_done1_1", 32'(if1.done), 1);
        a4 = 4'd5; b4 = 4'd11;
        @(negedge clk);
        st4 = 1'b0; a4 = 'x; b4 = 'x;
        check("b2b_busy0", 32'(if0.busy), 1);
        check("b2b_busy1", 32'(if1.busy), 1);
        check("b2b_done_low", 32'(if0.done), 0);
        l = 0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (if0.done) begin l = c; break; end
        end
        check("b2b_lat2", 32'(l), 5);
        check("b2b_p2_0", 32'(if0.product), 32'h37);
        check("b2b_p2_1", 32'(if1.product), 32'h37);

        st4 = 1'b1; sg4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
        @(negedge clk);
        st4 = 1'b0; a4 = 'x; b4 = 'x;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy0", 32'(if0.busy), 0);
        check("abort_done0", 32'(if0.done), 0);
        check("abort_prod0", 32'(if0.product), 0);
        check("abort_busy1", 32'(if1.busy), 0);
        check("abort_prod1", 32'(if1.product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (if0.done || if1.done || if0.busy) nd++;
        end
        check("abort_quiet", 32'(nd), 0);

        op8("w8_m128sq", 1, 8'h80, 8'h80);
        check("w8_m128sq_hand", 32'(if2.product), 32'h4000);
        op8("w8_255sq", 0, 8'hFF, 8'hFF);
        check("w8_255sq_hand", 32'(if2.product), 32'hFE01);
        op8("w8_m1x127", 1, 8'hFF, 8'h7F);
        check("w8_m1x127_hand", 32'(if2.product), 32'hFF81);
        for (int i = 0; i < 1000; i++) begin
            op8($sformatf("r%0d", i), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
